// File: rtl/dsi_pkg.sv
// Shared definitions for the DSI packet receive checker: long-DT list, ECC column
// table, CRC constants, FSM encoding and the ECC/CRC helper functions.
package dsi_pkg;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam int N_LONG_DT = 15;
  localparam logic [5:0] LONG_DT [N_LONG_DT] = '{
    6'h09, 6'h19, 6'h29, 6'h39, 6'h1A, 6'h0C, 6'h1C, 6'h2C,
    6'h0D, 6'h1D, 6'h3D, 6'h0E, 6'h1E, 6'h2E, 6'h3E
  };

  // Parity-bit membership of each header data bit, entry j = data bit j, bit i = P[i].
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_CRC     = 3'd2,
    ST_SKIP    = 3'd3,
    ST_DROP    = 3'd4
  } rx_state_t;

  function automatic logic is_long_dt(input logic [5:0] dt);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_LONG_DT; i++) begin
      if (dt == LONG_DT[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [5:0] ecc_gen(input logic [23:0] data);
    logic [5:0] ecc;
    ecc = '0;
    for (int j = 0; j < 24; j++) begin
      if (data[j]) ecc = ecc ^ ECC_COL[j];
    end
    return ecc;
  endfunction

  // One byte of the reflected CRC-16 (x^16+x^12+x^5+1), LSB first on the wire.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/dsi_ecc_correct.sv
// Combinational header ECC check: syndrome, single-bit correction, multi-bit detect.
module dsi_ecc_correct
  import dsi_pkg::*;
(
  input  logic [23:0] data,
  input  logic [5:0]  ecc,
  output logic [23:0] data_corr,
  output logic        corr,
  output logic        err
);

  logic [5:0] syn;
  logic       data_hit;
  logic       ecc_hit;

  always_comb begin
    syn       = ecc_gen(data) ^ ecc;
    data_corr = data;
    data_hit  = 1'b0;
    for (int j = 0; j < 24; j++) begin
      if (syn == ECC_COL[j]) begin
        data_corr[j] = ~data[j];
        data_hit     = 1'b1;
      end
    end
    // A one-hot syndrome means only a parity bit was hit; data is already right.
    ecc_hit = (syn != 6'd0) && ((syn & (syn - 6'd1)) == 6'd0);
    corr    = data_hit || ecc_hit;
    err     = (syn != 6'd0) && !corr;
  end

endmodule

// File: rtl/dsi_packet_rx_checker.sv
// DSI packet receive checker: header ECC correction, VC filtering, payload forwarding
// and trailing CRC-16 check. Optional CRC check enabled by DSI_RX_CRC_CHECK_EN.
module dsi_packet_rx_checker
  import dsi_pkg::*;
#(
  parameter logic [3:0] VC_MASK = 4'b1111
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_bytes,
  output logic        hdr_valid,
  output logic [7:0]  hdr_di,
  output logic [15:0] hdr_wc,
  output logic        hdr_long,
  output logic        hdr_ecc_corr,
  output logic        hdr_ecc_err,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [1:0]  out_bytes,
  output logic        pkt_done,
  output logic        pkt_crc_err,
  output logic        pkt_abort,
  output logic [2:0]  dbg_state
);

  // Handshake: in_valid qualifies every input beat and there is no backpressure;
  // every output is a registered pulse or qualified by its own valid, one cycle later.

  rx_state_t   state;
  logic [15:0] rem;
  logic [1:0]  chk_cnt;

  logic [23:0] hdr_corr;
  logic        h_corr;
  logic        h_err;

  logic [2:0]  nb;
  logic [2:0]  pay;
  logic [2:0]  left_bytes;
  logic [1:0]  need;
  logic [2:0]  take3;
  logic [1:0]  take;
  logic        finished;
  logic        in_pkt;
  logic        data_beat;
  logic        hdr_long_c;
  logic        vc_ok;
  logic [31:0] pay_data;
  logic        crc_bad;

  dsi_ecc_correct u_ecc (
    .data      (in_data[23:0]),
    .ecc       (in_data[29:24]),
    .data_corr (hdr_corr),
    .corr      (h_corr),
    .err       (h_err)
  );

  always_comb begin
    nb         = {1'b0, in_bytes} + 3'd1;
    pay        = (rem < {13'd0, nb}) ? rem[2:0] : nb;
    left_bytes = nb - pay;
    need       = 2'd2 - chk_cnt;
    take3      = (left_bytes > {1'b0, need}) ? {1'b0, need} : left_bytes;
    take       = take3[1:0];
    finished   = (rem == {13'd0, pay}) && (({1'b0, chk_cnt} + {1'b0, take}) == 3'd2);
    in_pkt     = (state == ST_PAYLOAD) || (state == ST_CRC);
    data_beat  = in_valid && !in_sop && (in_pkt || (state == ST_SKIP));
    hdr_long_c = is_long_dt(hdr_corr[5:0]);
    vc_ok      = VC_MASK[hdr_corr[7:6]];
    pay_data   = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < pay) pay_data[8*k +: 8] = in_data[8*k +: 8];
    end
  end

`ifdef DSI_RX_CRC_CHECK_EN
  logic [15:0] crc_q;
  logic [15:0] crc_chain [5];
  logic [15:0] crc_next;
  logic [7:0]  crc_lo_q;
  logic [7:0]  rx_lo;
  logic [7:0]  rx_hi;
  logic        load_long;

  always_comb begin
    crc_chain[0] = crc_q;
    for (int k = 0; k < 4; k++) begin
      crc_chain[k+1] = crc16_step(crc_chain[k], in_data[8*k +: 8]);
    end
    crc_next = crc_chain[pay];
    // Checksum bytes follow the payload in the same beat, low byte first.
    rx_lo = crc_lo_q;
    rx_hi = 8'h00;
    if (chk_cnt == 2'd0 && take != 2'd0) rx_lo = in_data[8*pay[1:0] +: 8];
    if (chk_cnt == 2'd0 && take == 2'd2) rx_hi = in_data[8*(pay[1:0] + 2'd1) +: 8];
    else if (chk_cnt == 2'd1 && take == 2'd1) rx_hi = in_data[8*pay[1:0] +: 8];
    crc_bad   = ({rx_hi, rx_lo} != crc_next);
    load_long = in_valid && in_sop && !h_err && vc_ok && hdr_long_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q    <= CRC_INIT;
      crc_lo_q <= '0;
    end else if (load_long) begin
      crc_q    <= CRC_INIT;
    end else if (data_beat && in_pkt) begin
      crc_q    <= crc_next;
      crc_lo_q <= rx_lo;
    end
  end
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      rem          <= '0;
      chk_cnt      <= '0;
      hdr_valid    <= 1'b0;
      hdr_di       <= '0;
      hdr_wc       <= '0;
      hdr_long     <= 1'b0;
      hdr_ecc_corr <= 1'b0;
      hdr_ecc_err  <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_bytes    <= '0;
      pkt_done     <= 1'b0;
      pkt_crc_err  <= 1'b0;
      pkt_abort    <= 1'b0;
    end else begin
      hdr_valid    <= 1'b0;
      hdr_ecc_corr <= 1'b0;
      hdr_ecc_err  <= 1'b0;
      out_valid    <= 1'b0;
      pkt_done     <= 1'b0;
      pkt_crc_err  <= 1'b0;
      pkt_abort    <= 1'b0;
      if (in_valid && in_sop) begin
        // A header always wins: an open long packet is closed as aborted.
        pkt_done  <= in_pkt;
        pkt_abort <= in_pkt;
        rem       <= hdr_corr[23:8];
        chk_cnt   <= '0;
        if (h_err) begin
          hdr_ecc_err <= 1'b1;
          state       <= ST_DROP;
        end else begin
          if (vc_ok) begin
            hdr_valid    <= 1'b1;
            hdr_di       <= hdr_corr[7:0];
            hdr_wc       <= hdr_corr[23:8];
            hdr_long     <= hdr_long_c;
            hdr_ecc_corr <= h_corr;
          end
          if (!hdr_long_c)                 state <= ST_IDLE;
          else if (!vc_ok)                 state <= ST_SKIP;
          else if (hdr_corr[23:8] == '0)   state <= ST_CRC;
          else                             state <= ST_PAYLOAD;
        end
      end else if (data_beat) begin
        rem     <= rem - {13'd0, pay};
        chk_cnt <= chk_cnt + take;
        if (state != ST_SKIP && pay != 3'd0) begin
          out_valid <= 1'b1;
          out_data  <= pay_data;
          out_bytes <= 2'(pay - 3'd1);
        end
        if (finished) begin
          state <= ST_IDLE;
          if (state != ST_SKIP) begin
            pkt_done    <= 1'b1;
            pkt_crc_err <= crc_bad;
          end
        end else if (state == ST_PAYLOAD && rem == {13'd0, pay}) begin
          state <= ST_CRC;
        end
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_dsi_packet_rx_checker.sv
// Bench for dsi_packet_rx_checker: directed header/CRC cases plus random packet streams
// scored against a packet-level reference model.
module tb_dsi_packet_rx_checker;

  localparam logic [3:0] VC_MASK = 4'b0011;
`ifdef DSI_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  // Parity equations P0..P5 as masks over the 24 header data bits.
  localparam logic [23:0] PMASK [6] = '{
    24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00
  };
  localparam logic [5:0] LONG_LIST [15] = '{
    6'h09, 6'h19, 6'h29, 6'h39, 6'h1A, 6'h0C, 6'h1C, 6'h2C,
    6'h0D, 6'h1D, 6'h3D, 6'h0E, 6'h1E, 6'h2E, 6'h3E
  };

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_bytes = '0;
  logic        hdr_valid, hdr_long, hdr_ecc_corr, hdr_ecc_err;
  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_bytes;
  logic        pkt_done, pkt_crc_err, pkt_abort;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [25:0] hdr_q [$];
  logic [33:0] exp_q [$];
  logic [1:0]  done_q [$];
  int          err_exp = 0;

  dsi_packet_rx_checker #(.VC_MASK(VC_MASK)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_sop       (in_sop),
    .in_data      (in_data),
    .in_bytes     (in_bytes),
    .hdr_valid    (hdr_valid),
    .hdr_di       (hdr_di),
    .hdr_wc       (hdr_wc),
    .hdr_long     (hdr_long),
    .hdr_ecc_corr (hdr_ecc_corr),
    .hdr_ecc_err  (hdr_ecc_err),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_bytes    (out_bytes),
    .pkt_done     (pkt_done),
    .pkt_crc_err  (pkt_crc_err),
    .pkt_abort    (pkt_abort),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] m_ecc(input logic [23:0] d);
    logic [5:0] e;
    for (int i = 0; i < 6; i++) e[i] = ^(d & PMASK[i]);
    return e;
  endfunction

  function automatic logic m_is_long(input logic [5:0] dt);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 15; i++) if (LONG_LIST[i] == dt) r = 1'b1;
    return r;
  endfunction

  // Bit-serial LFSR view of the CRC: feedback enters at the top, taps at x^12 and x^5.
  function automatic logic [15:0] m_crc(input bq_t b);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb    = c[0] ^ b[i][k];
        c     = {fb, c[15:1]};
        c[10] = c[10] ^ fb;
        c[3]  = c[3] ^ fb;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] byte_mask(input int p);
    return (p >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * p)) - 32'd1);
  endfunction

  // Decode by search: the corrected header is whichever single flip makes the ECC agree.
  task automatic m_decode(input logic [23:0] d, input logic [5:0] e,
                          output logic [23:0] dc, output logic corr, output logic err);
    logic [5:0] s;
    dc   = d;
    corr = 1'b0;
    err  = 1'b0;
    s    = m_ecc(d) ^ e;
    if (s != 6'd0) begin
      if ($countones(s) == 1) corr = 1'b1;
      else begin
        for (int j = 0; j < 24; j++) begin
          if (m_ecc(d ^ (24'd1 << j)) == e) begin
            dc   = d ^ (24'd1 << j);
            corr = 1'b1;
          end
        end
        err = !corr;
      end
    end
  endtask

  task automatic beat(input logic sop, input logic [31:0] d, input logic [1:0] nb);
    if ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      in_sop   = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      in_bytes = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_sop   = sop;
    in_data  = d;
    in_bytes = nb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input logic [23:0] dflip,
                          input logic [5:0] eflip, input logic [15:0] csum_xor,
                          input int trunc, input int chunk);
    logic [23:0] d, dc;
    logic [5:0]  e;
    logic [1:0]  etop;
    logic        corr, err, lng, acc;
    bq_t         tail, pl;
    logic [15:0] cs;
    logic [31:0] w;
    int          pos, n, p;
    d    = {wc, di};
    e    = m_ecc(d) ^ eflip;
    d    = d ^ dflip;
    etop = (chunk == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
    m_decode(d, e, dc, corr, err);
    lng = m_is_long(di[5:0]);
    acc = !err && VC_MASK[dc[7:6]];
    if (err) err_exp++;
    else if (acc) hdr_q.push_back({dc[7:0], dc[23:8], m_is_long(dc[5:0]), corr});
    beat(1'b1, {etop, e, d}, 2'd3);
    if (lng) begin
      pl = {};
      for (int i = 0; i < int'(wc); i++) pl.push_back(8'($urandom));
      cs   = m_crc(pl) ^ csum_xor;
      tail = pl;
      tail.push_back(cs[7:0]);
      tail.push_back(cs[15:8]);
      if (trunc >= 0) while (tail.size() > trunc) void'(tail.pop_back());
      pos = 0;
      while (pos < tail.size()) begin
        n = (chunk != 0) ? chunk : int'($urandom_range(1, 4));
        if (n > tail.size() - pos) n = tail.size() - pos;
        w = $urandom;
        p = 0;
        for (int k = 0; k < n; k++) begin
          w[8*k +: 8] = tail[pos+k];
          if (pos + k < int'(wc)) p++;
        end
        if (acc && p > 0) exp_q.push_back({2'(p - 1), w & byte_mask(p)});
        beat(1'b0, w, 2'(n - 1));
        pos += n;
      end
      if (acc) done_q.push_back((trunc >= 0) ? 2'b10 : {1'b0, CRC_EN && (csum_xor != 16'd0)});
    end else begin
      repeat (err ? $urandom_range(1, 2) : $urandom_range(0, 1))
        beat(1'b0, $urandom, 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check(tag, hdr_q.size() + exp_q.size() + done_q.size() + err_exp, 0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (hdr_valid) begin
        if (hdr_q.size() == 0) check("hdr_unexpected", hdr_valid, 1'b0);
        else check("hdr", {hdr_di, hdr_wc, hdr_long, hdr_ecc_corr}, hdr_q.pop_front());
      end
      if (hdr_ecc_err) begin
        if (err_exp == 0) check("ecc_err_unexpected", hdr_ecc_err, 1'b0);
        else begin
          err_exp--;
          check("ecc_err_hdr_valid", hdr_valid, 1'b0);
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("out_unexpected", out_valid, 1'b0);
        else check("out", {out_bytes, out_data & byte_mask(int'(out_bytes) + 1)}, exp_q.pop_front());
      end
      if (pkt_done) begin
        if (done_q.size() == 0) check("done_unexpected", pkt_done, 1'b0);
        else check("done", {pkt_abort, pkt_crc_err}, done_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0]  di;
    logic [15:0] wc;
    logic [23:0] dflip;
    logic [5:0]  eflip;
    int          j1, sel;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_hdr", {hdr_valid, hdr_di, hdr_wc, hdr_long, hdr_ecc_corr, hdr_ecc_err}, 0);
    check("rst_out", {out_valid, out_data, out_bytes}, 0);
    check("rst_pkt", {pkt_done, pkt_crc_err, pkt_abort}, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;

    send_pkt(8'h05, 16'h0011, 24'h0, 6'h00, 16'h0, -1, 4);
    drain("short_ok");
    send_pkt(8'h05, 16'h0011, 24'h1, 6'h00, 16'h0, -1, 4);
    drain("short_data_corr");
    send_pkt(8'h05, 16'h0011, 24'h0, 6'h01, 16'h0, -1, 4);
    drain("short_ecc_corr");
    send_pkt(8'h05, 16'h0011, 24'h3, 6'h00, 16'h0, -1, 4);
    drain("short_uncorr");
    send_pkt(8'h29, 16'h0000, 24'h0, 6'h00, 16'h0, -1, 2);
    drain("empty_crc_ok");
    send_pkt(8'h29, 16'h0000, 24'h0, 6'h00, 16'h0100, -1, 2);
    drain("empty_crc_bad");
    send_pkt(8'h39, 16'h0005, 24'h0, 6'h00, 16'h0, -1, 4);
    drain("wc5_straddle");
    send_pkt(8'h29, 16'h0006, 24'h0, 6'h00, 16'h0, 3, 4);
    send_pkt(8'h99, 16'h0004, 24'h0, 6'h00, 16'h0, -1, 0);
    send_pkt(8'h05, 16'h0011, 24'h0, 6'h00, 16'h0, -1, 4);
    drain("abort_then_skip");

    // Reset in the middle of a payload: the pending abort never happens.
    send_pkt(8'h29, 16'h0008, 24'h0, 6'h00, 16'h0, 4, 4);
    void'(done_q.pop_back());
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_rst", {hdr_valid, out_valid, pkt_done, dbg_state}, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    send_pkt(8'h05, 16'h0011, 24'h0, 6'h00, 16'h0, -1, 4);
    drain("after_mid_reset");

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        di = {2'($urandom_range(0, 3)), LONG_LIST[$urandom_range(0, 14)]};
        wc = 16'($urandom_range(0, 12));
      end else begin
        do di = 8'($urandom); while (m_is_long(di[5:0]));
        wc = 16'($urandom);
      end
      dflip = '0;
      eflip = '0;
      sel   = $urandom_range(0, 19);
      if (sel < 3) dflip = 24'd1 << $urandom_range(0, 23);
      else if (sel < 5) eflip = 6'd1 << $urandom_range(0, 5);
      else if (sel < 8) begin
        j1    = $urandom_range(0, 23);
        dflip = (24'd1 << j1) | (24'd1 << ((j1 + $urandom_range(1, 23)) % 24));
      end
      send_pkt(di, wc, dflip, eflip,
               ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0,
               ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, int'(wc) + 1)) : -1, 0);
    end
    send_pkt(8'h05, 16'h0011, 24'h0, 6'h00, 16'h0, -1, 4);
    drain("random_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
